ccip_c1tx_wr_arbiter: RTL and testbench

CCIP_C1TX_WR_ARBITER -- requirements
Module: ccip_c1tx_wr_arbiter

---
 rtl/ccip_c1tx_wr_arbiter.sv | 168 ++++++++++++++++
 tb/tb_ccip_c1tx_wr_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccip_c1tx_wr_arbiter.sv
// ccip_c1tx_wr_arbiter: two-requester round-robin write-burst arbiter
// feeding the CCI-P C1Tx channel with registered header/data outputs.
// Ports: req_* per-requester burst beats, req_ready beat consumed,
// C1TxAlmFull backpressure, C1TxWrValid/c1tx_*/C1TxData write request,
// err_illegal reject pulse, grant_id/busy/beat_count status.
module ccip_c1tx_wr_arbiter #(
  parameter int ADDR_WIDTH  = 42,
  parameter int DATA_WIDTH  = 512,
  parameter int MDATA_WIDTH = 16
) (
  input  logic                        clk,
  input  logic                        SoftReset_n,
  input  logic [1:0]                  req_valid,
  input  logic [1:0][1:0]             req_len,
  input  logic [1:0][ADDR_WIDTH-1:0]  req_addr,
  input  logic [1:0][MDATA_WIDTH-1:0] req_mdata,
  input  logic [1:0][DATA_WIDTH-1:0]  req_data,
  output logic [1:0]                  req_ready,
  input  logic                        C1TxAlmFull,
  output logic                        C1TxWrValid,
  output logic [ADDR_WIDTH-1:0]       c1tx_addr,
  output logic [1:0]                  c1tx_len,
  output logic                        c1tx_sop,
  output logic [MDATA_WIDTH-1:0]      c1tx_mdata,
  output logic [DATA_WIDTH-1:0]       C1TxData,
  output logic                        err_illegal,
  output logic                        grant_id,
  output logic                        busy,
  output logic [31:0]                 beat_count
);

  typedef enum logic {IDLE, BURST} state_e;

  state_e                 state_q, state_d;
  logic                   last_q, last_d;
  logic                   gnt_q, gnt_d;
  logic [1:0]             len_q, len_d;
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [MDATA_WIDTH-1:0] mdata_q, mdata_d;
  logic [1:0]             cnt_q, cnt_d;
  logic                   vld_q, vld_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
  logic [1:0]             olen_q, olen_d;
  logic                   sop_q, sop_d;
  logic [MDATA_WIDTH-1:0] omd_q, omd_d;
  logic [DATA_WIDTH-1:0]  data_q, data_d;
  logic [31:0]            bcnt_q, bcnt_d;

  logic                   cand;
  logic [1:0]             c_len;
  logic [ADDR_WIDTH-1:0]  c_addr;
  logic                   illegal;
  logic                   go;
  logic [1:0]             rdy;
  logic                   err;

  always_comb begin
    // last_q holds the last owner, so the other requester wins a tie
    cand    = (req_valid == 2'b11) ? ~last_q : req_valid[1];
    c_len   = req_len[cand];
    c_addr  = req_addr[cand];
    illegal = (c_len == 2'd2)
            || (c_len == 2'd1 && c_addr[0])
            || (c_len == 2'd3 && c_addr[1:0] != 2'd0);

    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    len_d   = len_q;
    base_d  = base_q;
    mdata_d = mdata_q;
    cnt_d   = cnt_q;
    vld_d   = 1'b0;
    addr_d  = addr_q;
    olen_d  = olen_q;
    sop_d   = sop_q;
    omd_d   = omd_q;
    data_d  = data_q;
    bcnt_d  = bcnt_q;
    rdy     = 2'b00;
    err     = 1'b0;
    go      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          last_d = cand;
          if (illegal) begin
            rdy[cand] = 1'b1;
            err       = 1'b1;
          end else begin
            gnt_d   = cand;
            len_d   = c_len;
            base_d  = c_addr;
            mdata_d = req_mdata[cand];
            cnt_d   = 2'd0;
            state_d = BURST;
          end
        end
      end
      BURST: begin
        go         = req_valid[gnt_q] && !C1TxAlmFull;
        rdy[gnt_q] = go;
        if (go) begin
          vld_d  = 1'b1;
          addr_d = base_q + ADDR_WIDTH'(cnt_q);
          olen_d = len_q;
          sop_d  = (cnt_q == 2'd0);
          omd_d  = mdata_q;
          data_d = req_data[gnt_q];
          bcnt_d = bcnt_q + 32'd1;
          cnt_d  = cnt_q + 2'd1;
          // legal encodings 0/1/3 equal beats-1
          if (cnt_q == len_q) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge SoftReset_n) begin
    if (!SoftReset_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      len_q   <= '0;
      base_q  <= '0;
      mdata_q <= '0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      addr_q  <= '0;
      olen_q  <= '0;
      sop_q   <= 1'b0;
      omd_q   <= '0;
      data_q  <= '0;
      bcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      len_q   <= len_d;
      base_q  <= base_d;
      mdata_q <= mdata_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      addr_q  <= addr_d;
      olen_q  <= olen_d;
      sop_q   <= sop_d;
      omd_q   <= omd_d;
      data_q  <= data_d;
      bcnt_q  <= bcnt_d;
    end
  end

  // combinational outputs are forced low while reset is held
  assign req_ready   = rdy & {2{SoftReset_n}};
  assign err_illegal = err & SoftReset_n;
  assign C1TxWrValid = vld_q;
  assign c1tx_addr   = addr_q;
  assign c1tx_len    = olen_q;
  assign c1tx_sop    = sop_q;
  assign c1tx_mdata  = omd_q;
  assign C1TxData    = data_q;
  assign grant_id    = gnt_q;
  assign busy        = (state_q == BURST);
  assign beat_count  = bcnt_q;

endmodule

// File: tb/tb_ccip_c1tx_wr_arbiter.sv
// tb_ccip_c1tx_wr_arbiter: directed bench with a beat scoreboard
// for the two-requester C1Tx write arbiter.
module tb_ccip_c1tx_wr_arbiter;
  localparam int AW = 42;
  localparam int DW = 512;
  localparam int MW = 16;

  typedef struct packed {
    logic          id;
    logic [AW-1:0] addr;
    logic [1:0]    len;
    logic          sop;
    logic [MW-1:0] md;
    logic [DW-1:0] data;
  } beat_t;

  logic                clk;
  logic                SoftReset_n;
  logic [1:0]          req_valid;
  logic [1:0][1:0]     req_len;
  logic [1:0][AW-1:0]  req_addr;
  logic [1:0][MW-1:0]  req_mdata;
  logic [1:0][DW-1:0]  req_data;
  logic [1:0]          req_ready;
  logic                C1TxAlmFull;
  logic                C1TxWrValid;
  logic [AW-1:0]       c1tx_addr;
  logic [1:0]          c1tx_len;
  logic                c1tx_sop;
  logic [MW-1:0]       c1tx_mdata;
  logic [DW-1:0]       C1TxData;
  logic                err_illegal;
  logic                grant_id;
  logic                busy;
  logic [31:0]         beat_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int left [2];
  int idx [2];
  logic [15:0] dtag [2];
  logic took [2];
  int err_cnt = 0;
  int rej_cnt [2];
  beat_t exp_q [$];
  int vld_cyc [$];
  int c0;
  bit found;

  ccip_c1tx_wr_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MDATA_WIDTH(MW)
  ) dut (
    .clk(clk), .SoftReset_n(SoftReset_n),
    .req_valid(req_valid), .req_len(req_len),
    .req_addr(req_addr), .req_mdata(req_mdata),
    .req_data(req_data), .req_ready(req_ready),
    .C1TxAlmFull(C1TxAlmFull), .C1TxWrValid(C1TxWrValid),
    .c1tx_addr(c1tx_addr), .c1tx_len(c1tx_len),
    .c1tx_sop(c1tx_sop), .c1tx_mdata(c1tx_mdata),
    .C1TxData(C1TxData), .err_illegal(err_illegal),
    .grant_id(grant_id), .busy(busy),
    .beat_count(beat_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] mkdata(
    input int i, input logic [15:0] t, input int k);
    logic [DW-1:0] d;
    d = '0;
    d[15:0] = k[15:0];
    d[31:16] = t;
    d[DW-1 -: 16] = ~t;
    d[DW-17 -: 8] = i[7:0];
    return d;
  endfunction

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = (left[i] != 0);
      req_data[i]  = mkdata(i, dtag[i], idx[i]);
    end
  end

  task automatic chk(input string tag,
                     input logic [639:0] o,
                     input logic [639:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  // requester model: a beat seen ready is consumed at the next edge
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (took[i]) begin
        left[i] = left[i] - 1;
        idx[i]  = idx[i] + 1;
        took[i] = 1'b0;
      end
    end
    #3;
    if (err_illegal) err_cnt = err_cnt + 1;
    for (int i = 0; i < 2; i++) begin
      took[i] = SoftReset_n && req_ready[i];
      if (err_illegal && req_ready[i])
        rej_cnt[i] = rej_cnt[i] + 1;
    end
  end

  always @(negedge clk) begin
    beat_t e;
    beat_t o;
    if (SoftReset_n && C1TxWrValid) begin
      vld_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", 640'(c1tx_addr), 640'(0));
      end else begin
        e = exp_q.pop_front();
        o = {grant_id, c1tx_addr, c1tx_len,
             c1tx_sop, c1tx_mdata, C1TxData};
        chk("beat", 640'(o), 640'(e));
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic start(input int i, input logic [1:0] len,
                       input logic [AW-1:0] a,
                       input logic [15:0] md,
                       input int beats, input int npush);
    beat_t b;
    req_len[i]   = len;
    req_addr[i]  = a;
    req_mdata[i] = md;
    dtag[i]      = md;
    idx[i]       = 0;
    for (int k = 0; k < npush; k++) begin
      b.id   = i[0];
      b.addr = a + AW'(k);
      b.len  = len;
      b.sop  = (k == 0);
      b.md   = md;
      b.data = mkdata(i, md, k);
      exp_q.push_back(b);
    end
    left[i] = beats;
  endtask

  task automatic push1(input int i, input logic [AW-1:0] a,
                       input logic [15:0] md, input int k);
    beat_t b;
    b.id   = i[0];
    b.addr = a;
    b.len  = 2'd0;
    b.sop  = 1'b1;
    b.md   = md;
    b.data = mkdata(i, md, k);
    exp_q.push_back(b);
  endtask

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy
            || left[0] != 0 || left[1] != 0)
           && n < budget) begin
      step();
      n++;
    end
    chk("drain_timeout", 640'(n < budget), 640'(1));
    step();
  endtask

  task automatic wait_left2(input string tag);
    found = 1'b0;
    for (int n = 0; n < 30 && !found; n++) begin
      step();
      if (left[0] == 2) found = 1'b1;
    end
    chk(tag, 640'(found), 640'(1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    SoftReset_n = 1'b0;
    C1TxAlmFull = 1'b0;
    req_len     = '0;
    req_addr    = '0;
    req_mdata   = '0;
    for (int i = 0; i < 2; i++) begin
      left[i] = 0; idx[i] = 0; dtag[i] = '0;
      took[i] = 1'b0; rej_cnt[i] = 0;
    end
    // illegal request held during reset must not leak out
    req_len[0] = 2'd2;
    left[0] = 1;
    step();
    step();
    chk("rst_vld", 640'(C1TxWrValid), 640'(0));
    chk("rst_busy", 640'(busy), 640'(0));
    chk("rst_bcnt", 640'(beat_count), 640'(0));
    chk("rst_ready", 640'(req_ready), 640'(0));
    chk("rst_err", 640'(err_illegal), 640'(0));
    chk("rst_hdr", 640'({c1tx_addr, c1tx_len, c1tx_sop,
        c1tx_mdata, grant_id}), 640'(0));
    chk("rst_data", 640'(C1TxData), 640'(0));
    left[0] = 0;
    req_len[0] = 2'd0;
    step();
    SoftReset_n = 1'b1;
    step();

    // single 4CL burst
    vld_cyc.delete();
    c0 = cyc;
    start(0, 2'd3, 42'h100, 16'hA001, 4, 4);
    drain(40);
    chk("b4_count", 640'(vld_cyc.size()), 640'(4));
    if (vld_cyc.size() > 0)
      chk("b4_latency", 640'(vld_cyc[0] - c0), 640'(2));
    chk("b4_bcnt", 640'(beat_count), 640'(4));
    chk("b4_idle", 640'(busy), 640'(0));

    // both requesters, 1CL each, last owner was 0
    vld_cyc.delete();
    push1(1, 42'h80, 16'hB100, 0);
    push1(0, 42'h40, 16'hB000, 0);
    push1(1, 42'h80, 16'hB100, 1);
    push1(0, 42'h40, 16'hB000, 1);
    req_len[0] = 2'd0; req_addr[0] = 42'h40;
    req_mdata[0] = 16'hB000; dtag[0] = 16'hB000;
    req_len[1] = 2'd0; req_addr[1] = 42'h80;
    req_mdata[1] = 16'hB100; dtag[1] = 16'hB100;
    idx[0] = 0; idx[1] = 0;
    left[0] = 2; left[1] = 2;
    drain(60);
    chk("rr_count", 640'(vld_cyc.size()), 640'(4));
    if (vld_cyc.size() == 4)
      for (int k = 1; k < 4; k++)
        chk("rr_gap", 640'(vld_cyc[k] - vld_cyc[k-1]), 640'(2));
    chk("rr_bcnt", 640'(beat_count), 640'(8));

    // 3CL request rejected
    vld_cyc.delete();
    err_cnt = 0; rej_cnt[0] = 0; rej_cnt[1] = 0;
    start(1, 2'd2, 42'h200, 16'hC000, 1, 0);
    drain(20);
    repeat (3) step();
    chk("len3_err", 640'(err_cnt), 640'(1));
    chk("len3_rdy1", 640'(rej_cnt[1]), 640'(1));
    chk("len3_novld", 640'(vld_cyc.size()), 640'(0));
    chk("len3_bcnt", 640'(beat_count), 640'(8));

    // misaligned 2CL rejected, aligned 2CL accepted
    err_cnt = 0; rej_cnt[0] = 0;
    start(0, 2'd1, 42'h101, 16'hD000, 1, 0);
    drain(20);
    chk("mis_err", 640'(err_cnt), 640'(1));
    chk("mis_rdy0", 640'(rej_cnt[0]), 640'(1));
    chk("mis_novld", 640'(vld_cyc.size()), 640'(0));
    start(0, 2'd1, 42'h102, 16'hD001, 2, 2);
    drain(30);
    chk("al_err", 640'(err_cnt), 640'(1));
    chk("al_count", 640'(vld_cyc.size()), 640'(2));
    chk("al_bcnt", 640'(beat_count), 640'(10));

    // almost-full stall after the second beat
    vld_cyc.delete();
    start(0, 2'd3, 42'h200, 16'hE000, 4, 4);
    wait_left2("stall_reach");
    C1TxAlmFull = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_novld", 640'(C1TxWrValid), 640'(0));
    end
    C1TxAlmFull = 1'b0;
    drain(40);
    chk("stall_count", 640'(vld_cyc.size()), 640'(4));
    if (vld_cyc.size() == 4)
      chk("stall_gap", 640'(vld_cyc[2] - vld_cyc[1]), 640'(6));
    chk("stall_bcnt", 640'(beat_count), 640'(14));

    // reset in the middle of a burst
    vld_cyc.delete();
    start(0, 2'd3, 42'h300, 16'hF000, 4, 2);
    wait_left2("mrst_reach");
    SoftReset_n = 1'b0;
    left[0] = 0;
    #1;
    chk("mrst_vld", 640'(C1TxWrValid), 640'(0));
    chk("mrst_hdr", 640'({c1tx_addr, c1tx_len, c1tx_sop,
        c1tx_mdata, grant_id, busy}), 640'(0));
    chk("mrst_data", 640'(C1TxData), 640'(0));
    chk("mrst_bcnt", 640'(beat_count), 640'(0));
    chk("mrst_q", 640'(exp_q.size()), 640'(0));
    step();
    step();
    SoftReset_n = 1'b1;
    step();
    vld_cyc.delete();
    c0 = cyc;
    start(0, 2'd0, 42'h400, 16'h1234, 1, 1);
    drain(20);
    chk("post_count", 640'(vld_cyc.size()), 640'(1));
    if (vld_cyc.size() > 0)
      chk("post_latency", 640'(vld_cyc[0] - c0), 640'(2));
    chk("post_bcnt", 640'(beat_count), 640'(1));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
